// File: rtl/bullet_pool_pkg.sv
// Shared game constants and types used by the bullet pool and its consumers.
package bullet_pool_pkg;

   localparam int unsigned BULLET_SLOTS    = 4;
   localparam int unsigned BULLET_COOLDOWN = 8;
   localparam int unsigned BULLET_STEP     = 6;
   localparam int unsigned BULLET_X_LIMIT  = 600;
   localparam int unsigned BULLET_X_W      = 12;
   localparam int unsigned BULLET_Y_W      = 11;

   typedef struct packed {
      logic                         valid;
      logic                         dir;
      logic signed [BULLET_X_W-1:0] x;
      logic signed [BULLET_Y_W-1:0] y;
   } bullet_slot_t;

   // Slot index width, never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bullet_pool_if.sv
// Fire/hit request bus and per-slot position bus between controller, pool and renderer.
interface bullet_pool_if
   import bullet_pool_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = BULLET_SLOTS,
   parameter int unsigned X_W       = BULLET_X_W,
   parameter int unsigned Y_W       = BULLET_Y_W
);
   localparam int unsigned IDX_W = idx_width(NUM_SLOTS);
   localparam int unsigned CNT_W = $clog2(NUM_SLOTS + 1);

   logic                     i_frame_tick;
   logic                     i_fire;
   logic [X_W-1:0]           i_spawn_x;
   logic [Y_W-1:0]           i_spawn_y;
   logic                     i_dir;
   logic                     i_hit_valid;
   logic [IDX_W-1:0]         i_hit_idx;
   logic [NUM_SLOTS-1:0]     o_valid;
   logic [NUM_SLOTS*X_W-1:0] o_x;
   logic [NUM_SLOTS*Y_W-1:0] o_y;
   logic                     o_fire_ack;
   logic [IDX_W-1:0]         o_ack_idx;
   logic [CNT_W-1:0]         o_count;
   logic                     o_full;

   modport master (
      output i_frame_tick, i_fire, i_spawn_x, i_spawn_y, i_dir, i_hit_valid, i_hit_idx,
      input  o_valid, o_x, o_y, o_fire_ack, o_ack_idx, o_count, o_full
   );

   modport slave (
      input  i_frame_tick, i_fire, i_spawn_x, i_spawn_y, i_dir, i_hit_valid, i_hit_idx,
      output o_valid, o_x, o_y, o_fire_ack, o_ack_idx, o_count, o_full
   );

endinterface

// File: rtl/bullet_pool_slot_alloc.sv
// Lowest-index free slot finder over the registered valid vector.
module slot_alloc #(
   parameter int unsigned NUM_SLOTS = 4,
   parameter int unsigned IDX_W     = 2
) (
   input  logic [NUM_SLOTS-1:0] valid,
   output logic                 found,
   output logic [IDX_W-1:0]     idx
);

   // Scan downward so the last hit is the lowest free index.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int k = int'(NUM_SLOTS) - 1; k >= 0; k--) begin
         if (!valid[k]) begin
            found = 1'b1;
            idx   = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/bullet_pool.sv
// Multi-slot projectile manager: allocates bullets on fire, steps them on frame
// ticks, and retires them on playfield exit or collision hit.
module bullet_pool
   import bullet_pool_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = BULLET_SLOTS,
   parameter int unsigned X_W       = BULLET_X_W,
   parameter int unsigned Y_W       = BULLET_Y_W,
   parameter int unsigned STEP      = BULLET_STEP,
   parameter int unsigned LIMIT     = BULLET_X_LIMIT,
   parameter int unsigned COOLDOWN  = BULLET_COOLDOWN
) (
   input logic         i_clk,
   input logic         i_rst,
   bullet_pool_if.slave bus
);

   localparam int unsigned IDX_W = idx_width(NUM_SLOTS);
   localparam int unsigned CNT_W = $clog2(NUM_SLOTS + 1);
   localparam int unsigned CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
   localparam logic signed [X_W:0] STEP_S = (X_W+1)'(STEP);
   localparam logic signed [X_W:0] LIM_S  = (X_W+1)'(LIMIT);

   logic [NUM_SLOTS-1:0] valid_q, valid_d;
   logic [NUM_SLOTS-1:0] dir_q, dir_d;
   logic signed [X_W-1:0] x_q [NUM_SLOTS];
   logic signed [X_W-1:0] x_d [NUM_SLOTS];
   logic signed [Y_W-1:0] y_q [NUM_SLOTS];
   logic signed [Y_W-1:0] y_d [NUM_SLOTS];
   logic signed [X_W:0]   moved [NUM_SLOTS];
   logic [CD_W-1:0]       cd_q, cd_d;
   logic                  ack_q, ack_d;
   logic [IDX_W-1:0]      ack_idx_q, ack_idx_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  full_q, full_d;
   logic                  free_found;
   logic [IDX_W-1:0]      free_idx;
   logic                  accept;

   slot_alloc #(
      .NUM_SLOTS(NUM_SLOTS),
      .IDX_W    (IDX_W)
   ) u_slot_alloc (
      .valid(valid_q),
      .found(free_found),
      .idx  (free_idx)
   );

   // Next state: tick motion first, then hit removal, then allocation into a free slot.
   always_comb begin
      valid_d   = valid_q;
      dir_d     = dir_q;
      x_d       = x_q;
      y_d       = y_q;
      cd_d      = cd_q;
      ack_idx_d = ack_idx_q;
      count_d   = '0;
      accept    = bus.i_fire && free_found && (cd_q == '0);
      ack_d     = accept;

      for (int k = 0; k < int'(NUM_SLOTS); k++) begin
         moved[k] = dir_q[k] ? ({x_q[k][X_W-1], x_q[k]} - STEP_S)
                             : ({x_q[k][X_W-1], x_q[k]} + STEP_S);
         if (bus.i_frame_tick && valid_q[k]) begin
            if (moved[k] > LIM_S || moved[k] < -LIM_S) valid_d[k] = 1'b0;
            else                                         x_d[k]     = moved[k][X_W-1:0];
         end
         if (bus.i_hit_valid && bus.i_hit_idx == IDX_W'(k)) valid_d[k] = 1'b0;
         if (accept && free_idx == IDX_W'(k)) begin
            valid_d[k] = 1'b1;
            dir_d[k]   = bus.i_dir;
            x_d[k]     = bus.i_spawn_x;
            y_d[k]     = bus.i_spawn_y;
         end
         count_d = count_d + CNT_W'(valid_d[k]);
      end
      full_d = &valid_d;

      if (accept) begin
         cd_d      = CD_W'(COOLDOWN);
         ack_idx_d = free_idx;
      end else if (bus.i_frame_tick && cd_q != '0) begin
         cd_d = cd_q - CD_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         valid_q   <= '0;
         dir_q     <= '0;
         cd_q      <= '0;
         ack_q     <= 1'b0;
         ack_idx_q <= '0;
         count_q   <= '0;
         full_q    <= 1'b0;
         for (int k = 0; k < int'(NUM_SLOTS); k++) begin
            x_q[k] <= '0;
            y_q[k] <= '0;
         end
      end else begin
         valid_q   <= valid_d;
         dir_q     <= dir_d;
         cd_q      <= cd_d;
         ack_q     <= ack_d;
         ack_idx_q <= ack_idx_d;
         count_q   <= count_d;
         full_q    <= full_d;
         for (int k = 0; k < int'(NUM_SLOTS); k++) begin
            x_q[k] <= x_d[k];
            y_q[k] <= y_d[k];
         end
      end
   end

   for (genvar k = 0; k < int'(NUM_SLOTS); k++) begin : g_pos
      assign bus.o_x[k*X_W +: X_W] = x_q[k];
      assign bus.o_y[k*Y_W +: Y_W] = y_q[k];
   end

   assign bus.o_valid    = valid_q;
   assign bus.o_fire_ack = ack_q;
   assign bus.o_ack_idx  = ack_idx_q;
   assign bus.o_count    = count_q;
   assign bus.o_full     = full_q;

endmodule

// File: tb/tb_bullet_pool.sv
// Random and directed checks of bullet_pool (cooldown 8 and cooldown 0 instances)
// against a slot-list reference model.
module tb_bullet_pool;

   localparam int N     = 4;
   localparam int XW    = 12;
   localparam int YW    = 11;
   localparam int STEP  = 6;
   localparam int LIMIT = 600;

   logic          clk = 1'b0;
   logic          rst, tick, fire, dir, hit_v;
   logic [XW-1:0] sx;
   logic [YW-1:0] sy;
   logic [1:0]    hidx;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bullet_pool_if #(.NUM_SLOTS(N), .X_W(XW), .Y_W(YW)) bif_a ();
   bullet_pool_if #(.NUM_SLOTS(N), .X_W(XW), .Y_W(YW)) bif_b ();

   assign bif_a.i_frame_tick = tick;  assign bif_b.i_frame_tick = tick;
   assign bif_a.i_fire       = fire;  assign bif_b.i_fire       = fire;
   assign bif_a.i_spawn_x    = sx;    assign bif_b.i_spawn_x    = sx;
   assign bif_a.i_spawn_y    = sy;    assign bif_b.i_spawn_y    = sy;
   assign bif_a.i_dir        = dir;   assign bif_b.i_dir        = dir;
   assign bif_a.i_hit_valid  = hit_v; assign bif_b.i_hit_valid  = hit_v;
   assign bif_a.i_hit_idx    = hidx;  assign bif_b.i_hit_idx    = hidx;

   bullet_pool #(.NUM_SLOTS(N), .X_W(XW), .Y_W(YW), .STEP(STEP), .LIMIT(LIMIT), .COOLDOWN(8))
      u_dut_a (.i_clk(clk), .i_rst(rst), .bus(bif_a));
   bullet_pool #(.NUM_SLOTS(N), .X_W(XW), .Y_W(YW), .STEP(STEP), .LIMIT(LIMIT), .COOLDOWN(0))
      u_dut_b (.i_clk(clk), .i_rst(rst), .bus(bif_b));

   // Reference model: [0] = cooldown 8 instance, [1] = cooldown 0 instance
   int m_cdcfg [2] = '{8, 0};
   bit m_v  [2][N];
   bit m_d  [2][N];
   int m_x  [2][N];
   int m_y  [2][N];
   int m_cd [2];
   bit m_ack[2];
   int m_aidx[2];

   task automatic chk(input string nm, input int i, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s inst%0d: got %0d expected %0d at %0t", nm, i, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < N; k++) begin
            m_v[i][k] = 0; m_d[i][k] = 0; m_x[i][k] = 0; m_y[i][k] = 0;
         end
         m_cd[i] = 0; m_ack[i] = 0; m_aidx[i] = 0;
      end
   endtask

   task automatic model_step();
      int  fidx, nx;
      bit  acc;
      if (rst) begin
         model_reset();
         return;
      end
      for (int i = 0; i < 2; i++) begin
         fidx = -1;
         for (int k = N - 1; k >= 0; k--) if (!m_v[i][k]) fidx = k;
         acc = fire && fidx >= 0 && m_cd[i] == 0;
         for (int k = 0; k < N; k++) begin
            if (tick && m_v[i][k]) begin
               nx = m_x[i][k] + (m_d[i][k] ? -STEP : STEP);
               if (nx > LIMIT || nx < -LIMIT) m_v[i][k] = 0;
               else                           m_x[i][k] = nx;
            end
         end
         if (hit_v) m_v[i][int'(hidx)] = 0;
         if (acc) begin
            m_v[i][fidx] = 1;
            m_d[i][fidx] = dir;
            m_x[i][fidx] = int'($signed(sx));
            m_y[i][fidx] = int'($signed(sy));
            m_cd[i]      = m_cdcfg[i];
            m_aidx[i]    = fidx;
         end else if (tick && m_cd[i] > 0) begin
            m_cd[i]--;
         end
         m_ack[i] = acc;
      end
   endtask

   task automatic cmp(input int i, input logic [N-1:0] v, input logic [N*XW-1:0] xs,
                      input logic [N*YW-1:0] ys, input logic ack, input logic [1:0] aidx,
                      input logic [2:0] cnt, input logic full);
      int ev, ec;
      ev = 0; ec = 0;
      for (int k = 0; k < N; k++) if (m_v[i][k]) begin ev |= (1 << k); ec++; end
      chk("valid", i, int'(v), ev);
      chk("count", i, int'(cnt), ec);
      chk("full", i, int'(full), int'(ec == N));
      chk("fire_ack", i, int'(ack), int'(m_ack[i]));
      chk("ack_idx", i, int'(aidx), m_aidx[i]);
      for (int k = 0; k < N; k++) begin
         chk($sformatf("x%0d", k), i, int'($signed(xs[k*XW +: XW])), m_x[i][k]);
         chk($sformatf("y%0d", k), i, int'($signed(ys[k*YW +: YW])), m_y[i][k]);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      cmp(0, bif_a.o_valid, bif_a.o_x, bif_a.o_y, bif_a.o_fire_ack, bif_a.o_ack_idx,
          bif_a.o_count, bif_a.o_full);
      cmp(1, bif_b.o_valid, bif_b.o_x, bif_b.o_y, bif_b.o_fire_ack, bif_b.o_ack_idx,
          bif_b.o_count, bif_b.o_full);
   endtask

   task automatic tick_pulse();
      tick = 1'b1; cycle(); tick = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; cycle(); rst = 1'b0;
   endtask

   initial begin
      model_reset();
      rst = 1'b1; tick = 0; fire = 0; dir = 0; hit_v = 0; sx = '0; sy = '0; hidx = '0;
      cycle(); cycle();
      chk("rst_valid_lit", 0, int'(bif_a.o_valid), 0);
      chk("rst_count_lit", 0, int'(bif_a.o_count), 0);
      rst = 1'b0;

      // Basic fire and motion
      fire = 1; sx = 12'sd100; sy = -11'sd200; dir = 0; cycle(); fire = 0;
      chk("fire_ack_lit", 0, int'(bif_a.o_fire_ack), 1);
      chk("slot0_valid_lit", 0, int'(bif_a.o_valid[0]), 1);
      chk("slot0_x_lit", 0, int'($signed(bif_a.o_x[XW-1:0])), 100);
      chk("slot0_y_lit", 0, int'($signed(bif_a.o_y[YW-1:0])), -200);
      for (int t = 0; t < 3; t++) begin tick_pulse(); cycle(); end
      chk("slot0_x_3tick_lit", 0, int'($signed(bif_a.o_x[XW-1:0])), 118);

      // Cooldown
      do_reset();
      fire = 1; sx = '0; sy = '0; cycle(); fire = 0;
      chk("cd_first_ack_lit", 0, int'(bif_a.o_fire_ack), 1);
      for (int t = 0; t < 7; t++) tick_pulse();
      fire = 1; cycle(); fire = 0;
      chk("cd_reject_lit", 0, int'(bif_a.o_fire_ack), 0);
      chk("cd0_accept_lit", 1, int'(bif_b.o_fire_ack), 1);
      tick_pulse();
      fire = 1; cycle(); fire = 0;
      chk("cd_accept_lit", 0, int'(bif_a.o_fire_ack), 1);
      chk("cd_accept_idx_lit", 0, int'(bif_a.o_ack_idx), 1);

      // Fill on the cooldown-0 instance
      do_reset();
      fire = 1; sx = 12'sd50;
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk("fill_ack_idx_lit", 1, int'(bif_b.o_ack_idx), k);
      end
      chk("fill_full_lit", 1, int'(bif_b.o_full), 1);
      chk("fill_count_lit", 1, int'(bif_b.o_count), 4);
      cycle(); fire = 0;
      chk("fill_fifth_lit", 1, int'(bif_b.o_fire_ack), 0);

      // Hit + tick + fire in the same cycle while full
      hit_v = 1; hidx = 2'd2; tick = 1; fire = 1; cycle();
      hit_v = 0; tick = 0;
      chk("simul_clear_lit", 1, int'(bif_b.o_valid[2]), 0);
      chk("simul_noack_lit", 1, int'(bif_b.o_fire_ack), 0);
      cycle(); fire = 0;
      chk("simul_realloc_lit", 1, int'(bif_b.o_ack_idx), 2);
      chk("simul_realloc_ack_lit", 1, int'(bif_b.o_fire_ack), 1);

      // Retire at both playfield edges
      do_reset();
      fire = 1; sx = 12'sd596; dir = 0; cycle(); fire = 0;
      tick_pulse();
      chk("retire_pos_lit", 1, int'(bif_b.o_valid[0]), 0);
      fire = 1; sx = -12'sd596; dir = 1; cycle(); fire = 0;
      chk("spawn_neg_lit", 1, int'(bif_b.o_valid[0]), 1);
      tick_pulse();
      chk("retire_neg_lit", 1, int'(bif_b.o_valid[0]), 0);
      chk("retire_x_hold_lit", 1, int'($signed(bif_b.o_x[XW-1:0])), -596);

      // Reset with live bullets and a pending fire
      fire = 1; dir = 0; sx = 12'sd10;
      for (int k = 0; k < 3; k++) cycle();
      rst = 1; cycle(); rst = 0; fire = 0;
      chk("midrst_valid_lit", 1, int'(bif_b.o_valid), 0);
      chk("midrst_ack_lit", 1, int'(bif_b.o_fire_ack), 0);

      // Random traffic
      for (int c = 0; c < 4000; c++) begin
         rst   = ($urandom_range(0, 299) == 0);
         tick  = ($urandom_range(0, 3) == 0);
         fire  = ($urandom_range(0, 2) == 0);
         hit_v = ($urandom_range(0, 5) == 0);
         hidx  = 2'($urandom_range(0, 3));
         dir   = 1'($urandom_range(0, 1));
         sx    = XW'($urandom);
         sy    = YW'($urandom);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
